// File: rtl/rgb_pwm_pkg.sv
// ============================================================================
// Module : rgb_pwm_pkg
// Brief  : Shared types and constants for the RGB PWM LED driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_pwm_pkg;

    // Board LED pins are active-low.
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    localparam int DUTY_W_DEF = 8;

    typedef struct packed {
        logic [DUTY_W_DEF-1:0] r;
        logic [DUTY_W_DEF-1:0] g;
        logic [DUTY_W_DEF-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// ============================================================================
// Module : pwm_channel
// Brief  : One LED channel: active duty register, optional gamma mapping
//          (RGB_PWM_GAMMA_EN) and registered active-low compare stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_pending,
    input  logic [DUTY_W-1:0] i_phase,
    output logic              o_pin
);

    logic [DUTY_W-1:0] w_mapped;
    logic [DUTY_W-1:0] r_active;
    logic              r_pin;

`ifdef RGB_PWM_GAMMA_EN
    // Square-law curve: upper half of the truncated 2*DUTY_W-bit product.
    assign w_mapped = DUTY_W'(({{DUTY_W{1'b0}}, i_pending} *
                               {{DUTY_W{1'b0}}, i_pending}) >> DUTY_W);
`else
    assign w_mapped = i_pending;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (i_load) begin
            r_active <= w_mapped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pin <= LED_OFF;
        end else begin
            r_pin <= (i_phase < r_active) ? LED_ON : LED_OFF;
        end
    end

    assign o_pin = r_pin;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
// ============================================================================
// Module : rgb_pwm_driver
// Brief  : Double-buffered 3-channel PWM driver for active-low RGB LED pins;
//          colours swap only at period boundaries. Option: RGB_PWM_GAMMA_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE = 47,
    parameter int DUTY_W   = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DUTY_W-1:0] in_r,
    input  logic [DUTY_W-1:0] in_g,
    input  logic [DUTY_W-1:0] in_b,
    output logic              RGB_R,
    output logic              RGB_G,
    output logic              RGB_B,
    output logic              period_start
);

    localparam int              c_PW           = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [c_PW-1:0] c_PRESCALE_MAX = c_PW'(PRESCALE);

    logic [c_PW-1:0]   r_presc;
    logic [DUTY_W-1:0] r_phase;
    logic              r_period_start;
    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    rgb_t              r_pending;
    logic              w_tick;
    logic              w_boundary;
    logic              w_accept;
    logic              w_load;

    assign w_tick     = (r_presc == c_PRESCALE_MAX);
    assign w_boundary = w_tick && (r_phase == {DUTY_W{1'b1}});
    assign in_ready   = (r_state == EMPTY);
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_phase        <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_presc        <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                r_phase <= r_phase + DUTY_W'(1);
            end
            r_period_start <= w_boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_pending <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pending <= '{r: in_r, g: in_g, b: in_b};
            end
        end
    end

    // A boundary while EMPTY leaves the active colour untouched, even if a
    // colour is accepted in that same cycle; it waits for the next boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (w_boundary) begin
                    w_state_nxt = EMPTY;
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    pwm_channel #(.DUTY_W(DUTY_W)) u_ch_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_pending (r_pending.r),
        .i_phase   (r_phase),
        .o_pin     (RGB_R)
    );

    pwm_channel #(.DUTY_W(DUTY_W)) u_ch_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_pending (r_pending.g),
        .i_phase   (r_phase),
        .o_pin     (RGB_G)
    );

    pwm_channel #(.DUTY_W(DUTY_W)) u_ch_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_pending (r_pending.b),
        .i_phase   (r_phase),
        .o_pin     (RGB_B)
    );

    assign period_start = r_period_start;

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
// ============================================================================
// Module : tb_rgb_pwm_driver
// Brief  : Directed self-checking bench for rgb_pwm_driver (PRESCALE=0, 8-bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r, in_g, in_b;
    logic       RGB_R, RGB_G, RGB_B;
    logic       period_start;

    int n_total = 0;
    int n_pass  = 0;

    rgb_pwm_driver #(.PRESCALE(0), .DUTY_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r         (in_r),
        .in_g         (in_g),
        .in_b         (in_b),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] eff(input logic [7:0] d);
`ifdef RGB_PWM_GAMMA_EN
        logic [15:0] p;
        p = 16'(d) * 16'(d);
        return p[15:8];
`else
        return d;
`endif
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Waits for period_start (bounded), counting cycles and cycles with any pin low.
    task automatic wait_ps(output int cyc, output int lows);
        cyc  = 0;
        lows = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!(RGB_R && RGB_G && RGB_B)) lows++;
        end while (!period_start && cyc < 2000);
    endtask

    // Call at the period_start negedge; samples one full period of pins.
    task automatic check_period(input logic [7:0] er, input logic [7:0] eg,
                                input logic [7:0] eb, input string tag);
        int mr, mg, mb;
        mr = 0; mg = 0; mb = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (RGB_R !== ((i < int'(er)) ? 1'b0 : 1'b1)) mr++;
            if (RGB_G !== ((i < int'(eg)) ? 1'b0 : 1'b1)) mg++;
            if (RGB_B !== ((i < int'(eb)) ? 1'b0 : 1'b1)) mb++;
        end
        chk(mr, 0, {tag, "_r_errs"});
        chk(mg, 0, {tag, "_g_errs"});
        chk(mb, 0, {tag, "_b_errs"});
        chk(period_start, 1, {tag, "_next_ps"});
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input string tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_r     = r;
        in_g     = g;
        in_b     = b;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 2000, 1, {tag, "_accept_timeout"});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int cyc, lows, n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_r     = '0;
        in_g     = '0;
        in_b     = '0;

        // Reset held 5 cycles
        repeat (5) @(negedge clk);
        chk({RGB_R, RGB_G, RGB_B}, 3'b111, "rst_pins");
        chk(in_ready, 1, "rst_ready");
        chk(period_start, 0, "rst_ps");

        // First period after release: all pins stay off
        rst_n = 1'b1;
        wait_ps(cyc, lows);
        chk(cyc, 256, "first_period_len");
        chk(lows, 0, "first_period_lows");

        // r=128, g=0, b=255 accepted mid-period
        send(8'd128, 8'd0, 8'd255, "c1");
        @(negedge clk);
        chk(in_ready, 0, "c1_ready_low");
        wait_ps(cyc, lows);
        chk(cyc, 255, "c1_wait_len");
        chk(in_ready, 1, "c1_ready_back");
        check_period(eff(8'd128), eff(8'd0), eff(8'd255), "c1");

        // Back-to-back colours: second stalls until the boundary
        send(8'd64, 8'd32, 8'd0, "ca");
        in_valid = 1'b1;
        in_r = 8'd16; in_g = 8'd0; in_b = 8'd200;
        @(negedge clk);
        chk(in_ready, 0, "cb_stall");
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(n, 255, "cb_stall_len");
        chk(period_start, 1, "cb_ready_at_ps");
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_period(eff(8'd64), eff(8'd32), eff(8'd0), "ca");
        check_period(eff(8'd16), eff(8'd0), eff(8'd200), "cb");

        // Accept coinciding with the boundary cycle
        repeat (255) @(negedge clk);
        in_valid = 1'b1;
        in_r = 8'd100; in_g = 8'd50; in_b = 8'd150;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk(period_start, 1, "cc_ps");
        chk(in_ready, 0, "cc_held");
        check_period(eff(8'd16), eff(8'd0), eff(8'd200), "cc_old");
        chk(in_ready, 1, "cc_ready_back");
        check_period(eff(8'd100), eff(8'd50), eff(8'd150), "cc");

        // Asynchronous reset while HELD with r=200
        send(8'd200, 8'd0, 8'd0, "cd");
        repeat (50) @(negedge clk);
        chk(in_ready, 0, "cd_held");
        chk(RGB_R, (eff(8'd100) > 8'd50) ? 1'b0 : 1'b1, "cd_pre_r");
        #2 rst_n = 1'b0;
        #1;
        chk({RGB_R, RGB_G, RGB_B}, 3'b111, "async_rst_pins");
        chk(in_ready, 1, "async_rst_ready");
        chk(period_start, 0, "async_rst_ps");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(in_ready, 1, "post_rst_ready");
        wait_ps(cyc, lows);
        chk(cyc, 256, "post_rst_period_len");
        chk(lows, 0, "post_rst_lows");
        check_period(8'd0, 8'd0, 8'd0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
